// File: rtl/adc_run_sequencer.sv
// MAX11043 run sequencer: plays the init table through SPI_ADC, then issues one data read per
// EOC falling edge and forwards host commands from the command FIFO between reads.
module adc_run_sequencer #(
   parameter logic [23:0] INIT_W0 = 24'h30101B,
   parameter logic [23:0] INIT_W1 = 24'h34101B,
   parameter logic [23:0] INIT_W2 = 24'h38101B,
   parameter logic [23:0] INIT_W3 = 24'h3C101B,
   parameter logic [23:0] RD_CMD  = 24'hC10000,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        CLOCK_50,
   input  logic        RST,
   input  logic        START,
   input  logic        STOP,
   input  logic        EOC,
   input  logic        CMD_VALID,
   input  logic [23:0] CMD_DATA,
   output logic        CMD_RD,
   output logic        SPI_REQ,
   output logic [23:0] SPI_DATA,
   input  logic        SPI_DONE,
   input  logic [63:0] SPI_RX,
   output logic        CONV_RUN,
   output logic        SAMPLE_VALID,
   output logic [63:0] SAMPLE,
   output logic [2:0]  STATE,
   output logic        OVERRUN,
   output logic        ERR
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_RUN   = 3'd2,
      ST_READ  = 3'd3,
      ST_HCMD  = 3'd4,
      ST_FAULT = 3'd5
   } state_t;

   localparam int unsigned TMO_W = $clog2(TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 32'd1);

   state_t           state_r, state_next;
   logic [1:0]       idx_r, idx_next;
   logic [TMO_W-1:0] tmo_r, tmo_next;
   logic             req_r, req_next;
   logic [23:0]      data_r, data_next;
   logic             cmd_rd_r, cmd_rd_next;
   logic             conv_run_r, conv_run_next;
   logic             sample_valid_r, sample_valid_next;
   logic [63:0]      sample_r, sample_next;
   logic             overrun_r, overrun_next;
   logic             err_r, err_next;
   logic             stop_pend_r, stop_pend_next;
   logic             eoc_s1_r, eoc_s2_r, eoc_prev_r;
   logic             eoc_fall_s, stop_any_s, xact_s;

   function automatic logic [23:0] init_word(input logic [1:0] idx);
      logic [23:0] w;
      case (idx)
         2'd0:    w = INIT_W0;
         2'd1:    w = INIT_W1;
         2'd2:    w = INIT_W2;
         2'd3:    w = INIT_W3;
         default: w = INIT_W0;
      endcase
      return w;
   endfunction

   assign eoc_fall_s = eoc_prev_r & ~eoc_s2_r;
   assign stop_any_s = STOP | stop_pend_r;
   assign xact_s     = (state_r == ST_INIT) || (state_r == ST_READ) || (state_r == ST_HCMD);

   // Next-state and next-output computation; a transaction state raises SPI_REQ on its first cycle.
   always_comb begin
      state_next        = state_r;
      idx_next          = idx_r;
      tmo_next          = tmo_r;
      req_next          = req_r;
      data_next         = data_r;
      cmd_rd_next       = 1'b0;
      sample_valid_next = 1'b0;
      sample_next       = sample_r;
      case (state_r)
         ST_IDLE: begin
            if (START) begin
               state_next = ST_INIT;
               idx_next   = 2'd0;
               data_next  = init_word(2'd0);
            end else if (CMD_VALID) begin
               state_next  = ST_HCMD;
               data_next   = CMD_DATA;
               cmd_rd_next = 1'b1;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (eoc_fall_s) begin
               state_next = ST_READ;
               data_next  = RD_CMD;
            end else if (CMD_VALID) begin
               state_next  = ST_HCMD;
               data_next   = CMD_DATA;
               cmd_rd_next = 1'b1;
            end else if (stop_any_s) begin
               state_next = ST_IDLE;
            end else begin
               state_next = ST_RUN;
            end
         end
         ST_INIT, ST_READ, ST_HCMD: begin
            if (!req_r) begin
               req_next = 1'b1;
               tmo_next = TMO_W'(0);
            end else if (SPI_DONE) begin
               req_next = 1'b0;
               if (state_r == ST_READ) begin
                  sample_next       = SPI_RX;
                  sample_valid_next = 1'b1;
                  state_next        = ST_RUN;
               end else if (state_r == ST_HCMD) begin
                  state_next = conv_run_r ? ST_RUN : ST_IDLE;
               end else if (idx_r == 2'd3) begin
                  state_next = ST_RUN;
                  idx_next   = 2'd0;
               end else begin
                  idx_next  = idx_r + 2'd1;
                  data_next = init_word(idx_r + 2'd1);
               end
            end else if (tmo_r == TMO_LAST) begin
               req_next   = 1'b0;
               state_next = ST_FAULT;
            end else begin
               tmo_next = tmo_r + TMO_W'(1);
            end
         end
         ST_FAULT: begin
            if (stop_any_s) begin
               state_next = ST_IDLE;
            end else begin
               state_next = ST_FAULT;
            end
         end
         default: begin
            state_next = ST_IDLE;
            req_next   = 1'b0;
         end
      endcase

      // Conversion stays enabled through reads and host commands issued while running.
      case (state_next)
         ST_RUN:            conv_run_next = 1'b1;
         ST_IDLE, ST_FAULT: conv_run_next = 1'b0;
         default:           conv_run_next = conv_run_r;
      endcase
      err_next       = err_r | (state_next == ST_FAULT);
      overrun_next   = overrun_r | (eoc_fall_s & xact_s);
      stop_pend_next = (state_next == ST_IDLE) ? 1'b0 : (stop_pend_r | STOP);
   end

   // State and output registers; EOC idles high so its synchronizer resets to 1.
   always_ff @(posedge CLOCK_50 or posedge RST) begin
      if (RST) begin
         state_r        <= ST_IDLE;
         idx_r          <= 2'd0;
         tmo_r          <= TMO_W'(0);
         req_r          <= 1'b0;
         data_r         <= 24'h000000;
         cmd_rd_r       <= 1'b0;
         conv_run_r     <= 1'b0;
         sample_valid_r <= 1'b0;
         sample_r       <= 64'h0;
         overrun_r      <= 1'b0;
         err_r          <= 1'b0;
         stop_pend_r    <= 1'b0;
         eoc_s1_r       <= 1'b1;
         eoc_s2_r       <= 1'b1;
         eoc_prev_r     <= 1'b1;
      end else begin
         state_r        <= state_next;
         idx_r          <= idx_next;
         tmo_r          <= tmo_next;
         req_r          <= req_next;
         data_r         <= data_next;
         cmd_rd_r       <= cmd_rd_next;
         conv_run_r     <= conv_run_next;
         sample_valid_r <= sample_valid_next;
         sample_r       <= sample_next;
         overrun_r      <= overrun_next;
         err_r          <= err_next;
         stop_pend_r    <= stop_pend_next;
         eoc_s1_r       <= EOC;
         eoc_s2_r       <= eoc_s1_r;
         eoc_prev_r     <= eoc_s2_r;
      end
   end

   assign CMD_RD       = cmd_rd_r;
   assign SPI_REQ      = req_r;
   assign SPI_DATA     = data_r;
   assign CONV_RUN     = conv_run_r;
   assign SAMPLE_VALID = sample_valid_r;
   assign SAMPLE       = sample_r;
   assign STATE        = state_r;
   assign OVERRUN      = overrun_r;
   assign ERR          = err_r;

endmodule

// File: tb/tb_adc_run_sequencer.sv
// Bench for adc_run_sequencer: SPI slave and command FIFO models, a transaction-level
// expectation queue checked every cycle, directed cases and randomized episodes.
module tb_adc_run_sequencer;

   localparam logic [23:0] RD = 24'hC10000;

   logic        CLOCK_50, RST, START, STOP, EOC, CMD_VALID, CMD_RD, SPI_REQ, SPI_DONE;
   logic        CONV_RUN, SAMPLE_VALID, OVERRUN, ERR;
   logic [23:0] CMD_DATA, SPI_DATA;
   logic [63:0] SPI_RX, SAMPLE;
   logic [2:0]  STATE;

   adc_run_sequencer dut (
      .CLOCK_50(CLOCK_50), .RST(RST), .START(START), .STOP(STOP), .EOC(EOC),
      .CMD_VALID(CMD_VALID), .CMD_DATA(CMD_DATA), .CMD_RD(CMD_RD),
      .SPI_REQ(SPI_REQ), .SPI_DATA(SPI_DATA), .SPI_DONE(SPI_DONE), .SPI_RX(SPI_RX),
      .CONV_RUN(CONV_RUN), .SAMPLE_VALID(SAMPLE_VALID), .SAMPLE(SAMPLE),
      .STATE(STATE), .OVERRUN(OVERRUN), .ERR(ERR)
   );

   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   int          checks, errors;
   logic [23:0] exp_words[$];
   logic [63:0] exp_samples[$];
   logic [23:0] fifo_q[$];
   logic [23:0] word_log[$];
   logic [2:0]  exp_mode;
   bit          exp_overrun, exp_err;
   bit          req_q, cur_is_read, served, spi_mute, rx_force_en;
   logic [63:0] rx_force;
   logic [23:0] held;
   int          cnt, spi_delay, sv_count, cmd_rd_count;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Per-cycle comparison of the DUT against the expected transaction stream.
   task automatic monitor();
      logic [23:0] w;
      if (RST) begin
         req_q = 1'b0;
      end else begin
         if (SPI_REQ && !req_q) begin
            if (exp_words.size() == 0) begin
               chk("unexpected_req", 64'(SPI_REQ), 64'd0);
            end else begin
               w = exp_words.pop_front();
               chk("req_word", 64'(SPI_DATA), 64'(w));
               cur_is_read = (w == RD);
               held = SPI_DATA;
               word_log.push_back(SPI_DATA);
            end
         end else if (SPI_REQ) begin
            chk("data_stable", 64'(SPI_DATA), 64'(held));
         end
         if (CMD_RD) begin
            cmd_rd_count++;
            chk("cmd_rd_valid", 64'(CMD_VALID), 64'd1);
            chk("cmd_rd_word", 64'(SPI_DATA), 64'(CMD_DATA));
         end
         if (SAMPLE_VALID) begin
            sv_count++;
            if (exp_samples.size() == 0) chk("unexpected_sample_valid", 64'(SAMPLE_VALID), 64'd0);
            else chk("sample", SAMPLE, exp_samples.pop_front());
         end
         req_q = SPI_REQ;
      end
   endtask

   // One clock: compare at negedge, then update FIFO and SPI slave just after posedge.
   task automatic tick();
      bit          rd;
      logic [23:0] junk;
      @(negedge CLOCK_50);
      monitor();
      rd = CMD_RD;
      @(posedge CLOCK_50);
      #1;
      if (rd && fifo_q.size() > 0) junk = fifo_q.pop_front();
      if (fifo_q.size() > 0) begin
         CMD_VALID = 1'b1;
         CMD_DATA  = fifo_q[0];
      end else begin
         CMD_VALID = 1'b0;
         CMD_DATA  = 24'h0;
      end
      SPI_DONE = 1'b0;
      if (!SPI_REQ) begin
         served = 1'b0;
         cnt = 0;
      end else if (!served && !spi_mute) begin
         if (cnt >= spi_delay) begin
            SPI_DONE = 1'b1;
            SPI_RX = rx_force_en ? rx_force : {$urandom(), $urandom()};
            served = 1'b1;
            if (cur_is_read) exp_samples.push_back(SPI_RX);
         end else begin
            cnt++;
         end
      end
   endtask

   task automatic wait_quiet(input string name);
      int n = 0;
      while ((exp_words.size() != 0 || SPI_REQ) && n < 3000) begin
         tick();
         n++;
      end
      if (n >= 3000) chk({name, "_wait_bound"}, 64'(n), 64'd0);
      repeat (6) tick();
   endtask

   task automatic check_quiet(input string name);
      chk({name, "_state"}, 64'(STATE), 64'(exp_mode));
      chk({name, "_conv_run"}, 64'(CONV_RUN), 64'(exp_mode == 3'd2));
      chk({name, "_overrun"}, 64'(OVERRUN), 64'(exp_overrun));
      chk({name, "_err"}, 64'(ERR), 64'(exp_err));
      chk({name, "_fifo_drained"}, 64'(fifo_q.size()), 64'd0);
      chk({name, "_samples_drained"}, 64'(exp_samples.size()), 64'd0);
   endtask

   task automatic do_start();
      START = 1'b1;
      tick();
      START = 1'b0;
      exp_words.push_back(24'h30101B);
      exp_words.push_back(24'h34101B);
      exp_words.push_back(24'h38101B);
      exp_words.push_back(24'h3C101B);
      exp_mode = 3'd2;
      wait_quiet("init");
   endtask

   function automatic logic [23:0] rand_cmd();
      logic [23:0] w = 24'($urandom());
      if (w == RD) w = w ^ 24'h000001;
      return w;
   endfunction

   task automatic push_cmd(input logic [23:0] w);
      fifo_q.push_back(w);
      exp_words.push_back(w);
   endtask

   // EOC fall and the CMD_VALID rise land on the same decision cycle.
   task automatic eoc_with_cmd(input logic [23:0] w);
      EOC = 1'b0;
      exp_words.push_back(RD);
      tick();
      push_cmd(w);
      tick();
      EOC = 1'b1;
      wait_quiet("eoc_cmd");
   endtask

   task automatic overrun_case();
      int n = 0;
      spi_delay = 8;
      EOC = 1'b0;
      exp_words.push_back(RD);
      tick();
      EOC = 1'b1;
      while (!SPI_REQ && n < 20) begin tick(); n++; end
      if (n >= 20) chk("overrun_req_bound", 64'(n), 64'd0);
      EOC = 1'b0;
      tick();
      EOC = 1'b1;
      exp_overrun = 1'b1;
      wait_quiet("overrun");
      check_quiet("overrun");
   endtask

   task automatic idle_cmd_and_restart();
      push_cmd(rand_cmd());
      wait_quiet("idle_cmd");
      check_quiet("idle_cmd");
      do_start();
      check_quiet("restart");
   endtask

   initial begin
      int lat, m, n0, r0, s0;
      logic [23:0] init_lits[4];
      RST = 1'b1; START = 1'b0; STOP = 1'b0; EOC = 1'b1; CMD_VALID = 1'b0;
      CMD_DATA = 24'h0; SPI_DONE = 1'b0; SPI_RX = 64'h0;
      checks = 0; errors = 0; spi_delay = 4; spi_mute = 1'b0; rx_force_en = 1'b0;
      rx_force = 64'h0; exp_mode = 3'd0; exp_overrun = 1'b0; exp_err = 1'b0;
      sv_count = 0; cmd_rd_count = 0; served = 1'b0; cnt = 0; held = 24'h0;
      init_lits[0] = 24'h30101B; init_lits[1] = 24'h34101B;
      init_lits[2] = 24'h38101B; init_lits[3] = 24'h3C101B;
      repeat (3) tick();
      chk("rst_state", 64'(STATE), 64'd0);
      chk("rst_req", 64'(SPI_REQ), 64'd0);
      chk("rst_data", 64'(SPI_DATA), 64'd0);
      chk("rst_conv", 64'(CONV_RUN), 64'd0);
      chk("rst_sample", SAMPLE, 64'd0);
      chk("rst_flags", 64'({CMD_RD, SAMPLE_VALID, OVERRUN, ERR}), 64'd0);
      RST = 1'b0;
      tick();

      // Init table with a slow SPI engine.
      spi_delay = 20;
      do_start();
      check_quiet("t1");
      chk("t1_word_count", 64'(word_log.size()), 64'd4);
      for (int i = 0; i < 4 && i < word_log.size(); i++)
         chk("t1_init_word", 64'(word_log[i]), 64'(init_lits[i]));

      // Single read with a fixed frame; EOC-to-request latency.
      spi_delay = 3;
      rx_force_en = 1'b1;
      rx_force = 64'h0123456789ABCDEF;
      s0 = sv_count;
      EOC = 1'b0;
      exp_words.push_back(RD);
      tick();
      EOC = 1'b1;
      lat = 1;
      while (!SPI_REQ && lat < 20) begin tick(); lat++; end
      chk("t2_latency", 64'(lat), 64'd4);
      wait_quiet("t2");
      rx_force_en = 1'b0;
      chk("t2_sample", SAMPLE, 64'h0123456789ABCDEF);
      chk("t2_sample_pulses", 64'(sv_count - s0), 64'd1);
      check_quiet("t2");

      // Read and host command arriving together: read first, one pop.
      n0 = word_log.size();
      r0 = cmd_rd_count;
      eoc_with_cmd(24'h100A55);
      chk("t3_word_count", 64'(word_log.size() - n0), 64'd2);
      if (word_log.size() >= n0 + 2) begin
         chk("t3_first", 64'(word_log[n0]), 64'hC10000);
         chk("t3_second", 64'(word_log[n0 + 1]), 64'h100A55);
      end
      chk("t3_pops", 64'(cmd_rd_count - r0), 64'd1);
      check_quiet("t3");

      overrun_case();

      // Randomized episodes from RUN.
      for (int ep = 0; ep < 40; ep++) begin
         spi_delay = int'($urandom_range(6, 1));
         case ($urandom_range(5, 0))
            0: begin
               EOC = 1'b0;
               exp_words.push_back(RD);
               repeat ($urandom_range(3, 1)) tick();
               EOC = 1'b1;
               wait_quiet("ep_eoc");
            end
            1: begin
               repeat ($urandom_range(3, 1)) push_cmd(rand_cmd());
               wait_quiet("ep_cmd");
            end
            2: eoc_with_cmd(rand_cmd());
            3: overrun_case();
            4: begin
               EOC = 1'b0;
               exp_words.push_back(RD);
               tick();
               tick();
               STOP = 1'b1;
               tick();
               STOP = 1'b0;
               EOC = 1'b1;
               exp_mode = 3'd0;
               wait_quiet("ep_stop_eoc");
               check_quiet("ep_stop_eoc");
               idle_cmd_and_restart();
            end
            default: begin
               STOP = 1'b1;
               tick();
               STOP = 1'b0;
               exp_mode = 3'd0;
               wait_quiet("ep_stop");
               check_quiet("ep_stop");
               idle_cmd_and_restart();
            end
         endcase
         check_quiet("ep");
      end

      // SPI engine never answers: fault after the timeout, leave via STOP.
      spi_mute = 1'b1;
      EOC = 1'b0;
      exp_words.push_back(RD);
      tick();
      EOC = 1'b1;
      lat = 1;
      while (!SPI_REQ && lat < 20) begin tick(); lat++; end
      m = 0;
      while (STATE != 3'd5 && m < 2000) begin tick(); m++; end
      chk("t5_timeout_cycles", 64'(m), 64'd1024);
      chk("t5_err", 64'(ERR), 64'd1);
      chk("t5_conv", 64'(CONV_RUN), 64'd0);
      chk("t5_req", 64'(SPI_REQ), 64'd0);
      spi_mute = 1'b0;
      STOP = 1'b1;
      tick();
      STOP = 1'b0;
      tick();
      exp_mode = 3'd0;
      exp_err = 1'b1;
      check_quiet("t5");

      // Reset in the middle of a read.
      do_start();
      spi_delay = 30;
      EOC = 1'b0;
      exp_words.push_back(RD);
      tick();
      EOC = 1'b1;
      lat = 1;
      while (!SPI_REQ && lat < 20) begin tick(); lat++; end
      repeat (3) tick();
      #3 RST = 1'b1;
      #1;
      chk("t6_req", 64'(SPI_REQ), 64'd0);
      chk("t6_state", 64'(STATE), 64'd0);
      chk("t6_conv", 64'(CONV_RUN), 64'd0);
      chk("t6_data", 64'(SPI_DATA), 64'd0);
      chk("t6_flags", 64'({OVERRUN, ERR}), 64'd0);
      exp_words.delete();
      exp_samples.delete();
      fifo_q.delete();
      exp_err = 1'b0;
      exp_overrun = 1'b0;
      exp_mode = 3'd0;
      repeat (2) tick();
      RST = 1'b0;
      tick();
      spi_delay = 2;
      do_start();
      check_quiet("t6_run");
      STOP = 1'b1;
      tick();
      STOP = 1'b0;
      tick();
      chk("t6_stop_conv", 64'(CONV_RUN), 64'd0);
      chk("t6_stop_state", 64'(STATE), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
